mega_alu_wb: RTL and testbench
==============================

# mega_alu_wb

Write-back stage directly downstream of the MEGA/XMEGA ALU. Captures the ALU result word, destination address and flag word each accepted instruction. Commits the result to an 8-bit-write register file, one byte per cycle; 16-bit results (MOVW, ADIW, SBIW, MUL family) take two cycles. Owns the architectural SREG that feeds the ALU's `sreg_in`, and exposes forwarding lookups so operand fetch sees results not yet written.

## Interface
- `PLATFORM`, "XILINX": target family tag; no functional effect here.
- `SREG_RESET`, 8'h00: SREG value after reset.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: ALU result present this cycle.
- `in_ready` out 1: stage can accept; transfer on `in_valid & in_ready`.
- `in_rda` in 5: destination register (low byte for wide results).
- `in_wide` in 1: result is 16-bit; high byte goes to `in_rda | 5'd1`.
- `in_wr_reg` in 1: result writes the register file (0 for CP/CPC/CPI/BST/SEx/CLx).
- `in_wr_sreg` in 1: `in_sreg` replaces SREG.
- `in_R` in 16: ALU result `R`.
- `in_sreg` in 8: ALU `sreg_out`.
- `sreg_io_we` in 1, `sreg_io_data` in 8: I/O-space write to SREG (OUT, RETI I-flag path).
- `rf_we` out 1, `rf_addr` out 5, `rf_data` out 8: register-file byte write port.
- `sreg` out 8: architectural SREG, to ALU `sreg_in`.
- `fwd_a_addr`, `fwd_b_addr` in 5: operand addresses from fetch.
- `fwd_a_hit`, `fwd_b_hit` out 1; `fwd_a_data`, `fwd_b_data` out 8: pending-write match and byte.
- `busy` out 1: a write is pending (state != IDLE).

## Operation
- Holding register `h_{rda,wide,wr_reg,R}` loads on every accepted transfer.
- FSM states IDLE, WR_LO, WR_HI:
  - IDLE: accept -> WR_LO, else stay.
  - WR_LO: `rf_we=h_wr_reg`, `rf_addr=h_rda`, `rf_data=h_R[7:0]`. If `h_wide` -> WR_HI; else accept -> WR_LO, no accept -> IDLE.
  - WR_HI: `rf_we=h_wr_reg`, `rf_addr=h_rda|1`, `rf_data=h_R[15:8]`. Accept -> WR_LO, else IDLE.
- `in_ready = IDLE | WR_HI | (WR_LO & ~h_wide)`, combinational from state only; never depends on `in_valid`.
- `rf_we=0` in IDLE. `rf_addr`/`rf_data` are don't-care when `rf_we=0`; drive 0.
- SREG updates on the accept edge when `in_wr_sreg`: `sreg <= in_sreg`. It is therefore correct for the next instruction presented to the ALU.
- If `sreg_io_we` and an SREG-writing accept coincide, `sreg_io_data` wins.
- `in_wr_reg=0` with `in_wide=1` still spends two cycles (no writes).
- Forwarding, per port x:
  - In WR_LO with `h_wr_reg`: hit when `fwd_x_addr==h_rda` (data `h_R[7:0]`), or when `h_wide` and `fwd_x_addr==h_rda|1` (data `h_R[15:8]`).
  - In WR_HI with `h_wr_reg`: hit only on `h_rda|1` (data `h_R[15:8]`).
  - Otherwise hit=0, data=0.
- Wide with odd `in_rda`: the high byte targets the same register; the second write overwrites the first. This is a decoder error and is not trapped.

## Timing
- Reset (async assert, sync release): state IDLE, `sreg=SREG_RESET`, holding regs 0. So `in_ready=1`, `rf_we=0`, `busy=0`, all fwd hits 0.
- Reset mid-WR_LO/WR_HI abandons pending writes immediately; there is no write on the following edge.
- Latency: accept at edge N -> low-byte write visible (`rf_we=1`) in cycle N+1, high byte in N+2.
- Throughput: narrow 1/cycle back-to-back; wide 1 per 2 cycles (`in_ready=0` during WR_LO of a wide result).
- Forward outputs are combinational from state/holding regs and fwd addresses: zero-cycle lookup.
- SREG visible on `sreg` the cycle after the accept or I/O write edge.

## Test plan
- Reset: assert `rst=0` mid-WR_HI with `h_R=16'hBEEF` -> `rf_we` drops asynchronously; after release `sreg=SREG_RESET`, `in_ready=1`, no write of 8'hBE.
- Narrow back-to-back: ADD r5=8'h3C then AND r6=8'h10 on consecutive cycles -> `rf_we` 2 consecutive cycles, (5,3C) then (6,10), `in_ready` stays 1.
- Wide: MUL result 16'h1234 to rda=0 followed immediately by valid SUB r2 -> writes (0,34), (1,12); `in_ready=0` in the (0,34) cycle; SUB accepted in the (1,12) cycle, then (2,xx) next.
- Forwarding: during the (0,34) cycle, `fwd_a_addr=1`, `fwd_b_addr=0` -> a hit 8'h12, b hit 8'h34. During the (1,12) cycle, `fwd_b_addr=0` -> b hit 0.
- SREG: CP accept with `in_wr_reg=0`, `in_sreg=8'h02` -> no `rf_we`, `sreg=8'h02` next cycle. The same edge with `sreg_io_we=1`, `sreg_io_data=8'h80` -> `sreg=8'h80`.
- Idle: `in_valid=0` for 3 cycles after a narrow write -> state IDLE, `busy=0`, `rf_we=0`, `sreg` unchanged.

Source files
------------

// File: rtl/mega_alu_wb.sv
// Write-back stage behind the MEGA/XMEGA ALU: byte-serial register-file commit,
// architectural SREG ownership and zero-cycle forwarding of pending writes.
module mega_alu_wb #(
  parameter string      PLATFORM   = "XILINX",
  parameter logic [7:0] SREG_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rda,
  input  logic        in_wide,
  input  logic        in_wr_reg,
  input  logic        in_wr_sreg,
  input  logic [15:0] in_R,
  input  logic [7:0]  in_sreg,
  input  logic        sreg_io_we,
  input  logic [7:0]  sreg_io_data,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [7:0]  rf_data,
  output logic [7:0]  sreg,
  input  logic [4:0]  fwd_a_addr,
  input  logic [4:0]  fwd_b_addr,
  output logic        fwd_a_hit,
  output logic        fwd_b_hit,
  output logic [7:0]  fwd_a_data,
  output logic [7:0]  fwd_b_data,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WR_LO = 2'd1;
  localparam logic [1:0] S_WR_HI = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [4:0]  r_h_rda;
  logic        r_h_wide;
  logic        r_h_wr_reg;
  logic [15:0] r_h_R;
  logic [7:0]  r_sreg;
  logic        w_accept;
  logic [8:0]  w_fwd_a;
  logic [8:0]  w_fwd_b;

  // Returns {hit, byte} for a fetch address against the write in flight.
  function automatic logic [8:0] fwd_lookup(
    input logic [4:0]  addr,
    input logic [1:0]  st,
    input logic [4:0]  rda,
    input logic        wide,
    input logic        wr,
    input logic [15:0] r
  );
    logic [8:0] res;
    res = 9'd0;
    if (wr && (st == S_WR_LO) && (addr == rda)) begin
      res = {1'b1, r[7:0]};
    end else if (wr && (st == S_WR_LO) && wide && (addr == (rda | 5'd1))) begin
      res = {1'b1, r[15:8]};
    end else if (wr && (st == S_WR_HI) && (addr == (rda | 5'd1))) begin
      res = {1'b1, r[15:8]};
    end else begin
      res = 9'd0;
    end
    return res;
  endfunction

  assign in_ready = (r_state == S_IDLE) || (r_state == S_WR_HI) ||
                    ((r_state == S_WR_LO) && !r_h_wide);
  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state != S_IDLE);
  assign sreg     = r_sreg;

  // Next-state selection for the byte-commit sequencer.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = w_accept ? S_WR_LO : S_IDLE;
      S_WR_LO: begin
        if (r_h_wide) begin
          w_state_nxt = S_WR_HI;
        end else begin
          w_state_nxt = w_accept ? S_WR_LO : S_IDLE;
        end
      end
      S_WR_HI: w_state_nxt = w_accept ? S_WR_LO : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, holding register and SREG; the I/O-space write overrides the ALU flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_h_rda    <= 5'd0;
      r_h_wide   <= 1'b0;
      r_h_wr_reg <= 1'b0;
      r_h_R      <= 16'd0;
      r_sreg     <= SREG_RESET;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_h_rda    <= in_rda;
        r_h_wide   <= in_wide;
        r_h_wr_reg <= in_wr_reg;
        r_h_R      <= in_R;
      end else begin
        r_h_rda    <= r_h_rda;
        r_h_wide   <= r_h_wide;
        r_h_wr_reg <= r_h_wr_reg;
        r_h_R      <= r_h_R;
      end
      if (sreg_io_we) begin
        r_sreg <= sreg_io_data;
      end else if (w_accept && in_wr_sreg) begin
        r_sreg <= in_sreg;
      end else begin
        r_sreg <= r_sreg;
      end
    end
  end

  // Register-file byte port, decoded from state and holding register.
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = 5'd0;
    rf_data = 8'd0;
    case (r_state)
      S_WR_LO: begin
        rf_we   = r_h_wr_reg;
        rf_addr = r_h_wr_reg ? r_h_rda : 5'd0;
        rf_data = r_h_wr_reg ? r_h_R[7:0] : 8'd0;
      end
      S_WR_HI: begin
        rf_we   = r_h_wr_reg;
        rf_addr = r_h_wr_reg ? (r_h_rda | 5'd1) : 5'd0;
        rf_data = r_h_wr_reg ? r_h_R[15:8] : 8'd0;
      end
      default: begin
        rf_we   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 8'd0;
      end
    endcase
  end

  assign w_fwd_a    = fwd_lookup(fwd_a_addr, r_state, r_h_rda, r_h_wide, r_h_wr_reg, r_h_R);
  assign w_fwd_b    = fwd_lookup(fwd_b_addr, r_state, r_h_rda, r_h_wide, r_h_wr_reg, r_h_R);
  assign fwd_a_hit  = w_fwd_a[8];
  assign fwd_a_data = w_fwd_a[7:0];
  assign fwd_b_hit  = w_fwd_b[8];
  assign fwd_b_data = w_fwd_b[7:0];

endmodule

// File: tb/tb_mega_alu_wb.sv
// Scoreboard bench for mega_alu_wb: expected register-file writes are queued
// when an instruction is presented and popped as the DUT commits them.
module tb_mega_alu_wb;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rda;
  logic        in_wide;
  logic        in_wr_reg;
  logic        in_wr_sreg;
  logic [15:0] in_R;
  logic [7:0]  in_sreg;
  logic        sreg_io_we;
  logic [7:0]  sreg_io_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [7:0]  rf_data;
  logic [7:0]  sreg;
  logic [4:0]  fwd_a_addr;
  logic [4:0]  fwd_b_addr;
  logic        fwd_a_hit;
  logic        fwd_b_hit;
  logic [7:0]  fwd_a_data;
  logic [7:0]  fwd_b_data;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  logic [12:0] sb_q[$];

  mega_alu_wb #(.PLATFORM("XILINX"), .SREG_RESET(8'h00)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rda(in_rda), .in_wide(in_wide),
    .in_wr_reg(in_wr_reg), .in_wr_sreg(in_wr_sreg), .in_R(in_R), .in_sreg(in_sreg),
    .sreg_io_we(sreg_io_we), .sreg_io_data(sreg_io_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .sreg(sreg),
    .fwd_a_addr(fwd_a_addr), .fwd_b_addr(fwd_b_addr),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] addr, input logic [7:0] data);
    sb_q.push_back({addr, data});
  endtask

  // Present one instruction and return one step after the edge that accepted it.
  task automatic send(input logic [4:0] rda, input logic wide, input logic wr_reg,
                      input logic wr_sreg, input logic [15:0] r, input logic [7:0] s);
    int n;
    in_valid = 1'b1; in_rda = rda; in_wide = wide; in_wr_reg = wr_reg;
    in_wr_sreg = wr_sreg; in_R = r; in_sreg = s;
    n = 0;
    while (!in_ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", {15'd0, in_ready}, 16'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard side: every committed byte must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && rf_we) begin
      if (sb_q.size() == 0) begin
        chk("spurious_wr", {15'd0, rf_we}, 16'd0);
      end else begin
        chk("rf_write", {3'd0, rf_addr, rf_data}, {3'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_rda = 5'd0; in_wide = 1'b0; in_wr_reg = 1'b0;
    in_wr_sreg = 1'b0; in_R = 16'd0; in_sreg = 8'd0;
    sreg_io_we = 1'b0; sreg_io_data = 8'd0;
    fwd_a_addr = 5'd0; fwd_b_addr = 5'd0;
    @(posedge clk); #1;
    chk("rst_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_rf_we", {15'd0, rf_we}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_sreg", {8'd0, sreg}, 16'h0000);
    chk("rst_fwd", {14'd0, fwd_a_hit, fwd_b_hit}, 16'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Narrow back-to-back: ADD r5 then AND r6
    expect_wr(5'd5, 8'h3C);
    send(5'd5, 1'b0, 1'b1, 1'b0, 16'h003C, 8'h00);
    chk("nar0_we", {15'd0, rf_we}, 16'd1);
    chk("nar0_addr", {11'd0, rf_addr}, 16'd5);
    chk("nar0_ready", {15'd0, in_ready}, 16'd1);
    expect_wr(5'd6, 8'h10);
    send(5'd6, 1'b0, 1'b1, 1'b0, 16'h0010, 8'h00);
    chk("nar1_we", {15'd0, rf_we}, 16'd1);
    chk("nar1_wr", {3'd0, rf_addr, rf_data}, {3'd0, 5'd6, 8'h10});

    // Idle for three cycles
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_busy", {15'd0, busy}, 16'd0);
    chk("idle_we", {15'd0, rf_we}, 16'd0);
    chk("idle_sreg", {8'd0, sreg}, 16'h0000);

    // Wide MUL to r0 immediately followed by SUB r2
    expect_wr(5'd0, 8'h34);
    expect_wr(5'd1, 8'h12);
    send(5'd0, 1'b1, 1'b1, 1'b0, 16'h1234, 8'h00);
    fwd_a_addr = 5'd1; fwd_b_addr = 5'd0; #1;
    chk("wlo_ready", {15'd0, in_ready}, 16'd0);
    chk("wlo_wr", {3'd0, rf_addr, rf_data}, {3'd0, 5'd0, 8'h34});
    chk("wlo_fwd_a", {7'd0, fwd_a_hit, fwd_a_data}, {7'd0, 1'b1, 8'h12});
    chk("wlo_fwd_b", {7'd0, fwd_b_hit, fwd_b_data}, {7'd0, 1'b1, 8'h34});
    in_valid = 1'b1; in_rda = 5'd2; in_wide = 1'b0; in_wr_reg = 1'b1; in_R = 16'h0077;
    expect_wr(5'd2, 8'h77);
    @(posedge clk); #1;
    chk("whi_ready", {15'd0, in_ready}, 16'd1);
    chk("whi_wr", {3'd0, rf_addr, rf_data}, {3'd0, 5'd1, 8'h12});
    chk("whi_fwd_a", {7'd0, fwd_a_hit, fwd_a_data}, {7'd0, 1'b1, 8'h12});
    chk("whi_fwd_b", {7'd0, fwd_b_hit, fwd_b_data}, 16'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("sub_wr", {3'd0, rf_addr, rf_data}, {3'd0, 5'd2, 8'h77});
    fwd_a_addr = 5'd0; fwd_b_addr = 5'd0;

    // SREG: CP, then CP colliding with an I/O write, then an I/O write alone
    send(5'd7, 1'b0, 1'b0, 1'b1, 16'h0055, 8'h02);
    chk("cp_we", {15'd0, rf_we}, 16'd0);
    chk("cp_sreg", {8'd0, sreg}, 16'h0002);
    sreg_io_we = 1'b1; sreg_io_data = 8'h80;
    send(5'd7, 1'b0, 1'b0, 1'b1, 16'h0055, 8'h02);
    sreg_io_we = 1'b0;
    chk("io_wins", {8'd0, sreg}, 16'h0080);
    sreg_io_we = 1'b1; sreg_io_data = 8'h81;
    @(posedge clk); #1;
    sreg_io_we = 1'b0;
    chk("io_only", {8'd0, sreg}, 16'h0081);

    // Wide with no register write still takes two cycles
    send(5'd8, 1'b1, 1'b0, 1'b0, 16'hAAAA, 8'h00);
    chk("nw_lo", {13'd0, busy, rf_we, in_ready}, {13'd0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    chk("nw_hi", {13'd0, busy, rf_we, in_ready}, {13'd0, 1'b1, 1'b0, 1'b1});
    @(posedge clk); #1;
    chk("nw_idle", {15'd0, busy}, 16'd0);

    // Reset during WR_HI of 16'hBEEF: the 8'hBE byte must never be written
    expect_wr(5'd10, 8'hEF);
    send(5'd10, 1'b1, 1'b1, 1'b1, 16'hBEEF, 8'h44);
    chk("bf_sreg", {8'd0, sreg}, 16'h0044);
    @(posedge clk); #1;
    chk("bf_hi_we", {15'd0, rf_we}, 16'd1);
    chk("bf_hi_data", {8'd0, rf_data}, 16'h00BE);
    rst = 1'b0; #1;
    fwd_a_addr = 5'd11; fwd_b_addr = 5'd10; #1;
    chk("arst_we", {15'd0, rf_we}, 16'd0);
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_fwd", {14'd0, fwd_a_hit, fwd_b_hit}, 16'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("post_sreg", {8'd0, sreg}, 16'h0000);
    chk("post_ready", {15'd0, in_ready}, 16'd1);
    chk("post_we", {15'd0, rf_we}, 16'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("sb_empty", sb_q.size(), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
